// File: rtl/iter_divider.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU, returning {remainder, quotient}.
// One quotient bit per cycle on operand magnitudes; signs are applied in a single fix-up cycle.
module iter_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  div_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        div_in_valid,
    output logic        div_in_ready,
    output logic [63:0] div_result,
    output logic        div_out_valid,
    input  logic        div_out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dq_q, dq_d;
    logic [31:0] dvs_q, dvs_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [63:0] res_q, res_d;

    logic        sgn;
    logic [32:0] shifted;
    logic [32:0] trial;

    // 2'b00 and 2'b10 are unsigned; bit0 wins when both are set.
    always_comb begin
        unique case (div_op)
            2'b01, 2'b11: sgn = 1'b1;
            default:      sgn = 1'b0;
        endcase
    end

    // The partial remainder is kept at 32 bits: a restored remainder is always
    // below the divisor, so its 33rd bit would only ever hold zero.
    assign shifted = {rem_q, dq_q[31]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;

        unique case (state_q)
            S_IDLE: begin
                if (div_in_valid) begin
                    state_d = S_BUSY;
                    qneg_d  = sgn & (dividend[31] ^ divisor[31]);
                    rneg_d  = sgn & dividend[31];
                    dq_d    = (sgn && dividend[31]) ? (32'd0 - dividend) : dividend;
                    dvs_d   = (sgn && divisor[31])  ? (32'd0 - divisor)  : divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    dq_d  = {dq_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[31:0];
                    dq_d  = {dq_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Divide-by-zero and INT_MIN/-1 results fall out of the magnitude loop here.
                res_d[63:32] = rneg_q ? (32'd0 - rem_q) : rem_q;
                res_d[31:0]  = qneg_q ? (32'd0 - dq_q)  : dq_q;
                state_d      = S_DONE;
            end
            S_DONE: begin
                if (div_out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign div_in_ready  = (state_q == S_IDLE);
    assign div_out_valid = (state_q == S_DONE);
    assign div_result    = res_q;

endmodule

// File: tb/tb_iter_divider.sv
// Randomized and directed check of iter_divider against a plain-arithmetic divide model,
// including latency, backpressure, busy-input isolation and mid-operation reset.
module tb_iter_divider;

    logic        clk;
    logic        reset;
    logic [1:0]  div_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_in_valid;
    logic        div_in_ready;
    logic [63:0] div_result;
    logic        div_out_valid;
    logic        div_out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    iter_divider dut (
        .clk           (clk),
        .reset         (reset),
        .div_op        (div_op),
        .dividend      (dividend),
        .divisor       (divisor),
        .div_in_valid  (div_in_valid),
        .div_in_ready  (div_in_ready),
        .div_result    (div_result),
        .div_out_valid (div_out_valid),
        .div_out_ready (div_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // MIPS DIV/DIVU semantics: truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        s = op[0];
        if (b == 32'd0) begin
            q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one division, check latency, result, hold under backpressure and the return to idle.
    task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int stall, input bit noise);
        int          n;
        logic [63:0] hold;
        div_op       = op;
        dividend     = a;
        divisor      = b;
        div_in_valid = 1'b1;
        chk("in_ready_idle", 64'(div_in_ready), 64'd1);
        @(posedge clk); #1;
        n = 0;
        while (n < 100 && !div_out_valid) begin
            if (noise) begin
                div_in_valid = 1'($urandom);
                dividend     = $urandom;
                divisor      = $urandom;
                div_op       = 2'($urandom);
            end else begin
                div_in_valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        div_in_valid = 1'b0;
        chk("latency", 64'(n), 64'd33);
        chk("result", div_result, exp);
        chk("in_ready_done", 64'(div_in_ready), 64'd0);
        hold          = div_result;
        div_out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(div_out_valid), 64'd1);
            chk("hold_result", div_result, hold);
            chk("hold_in_ready", 64'(div_in_ready), 64'd0);
        end
        div_out_ready = 1'b1;
        @(posedge clk); #1;
        div_out_ready = 1'b0;
        chk("xfer_valid", 64'(div_out_valid), 64'd0);
        chk("xfer_in_ready", 64'(div_in_ready), 64'd1);
        chk("result_kept", div_result, hold);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        reset         = 1'b1;
        div_op        = 2'b00;
        dividend      = '0;
        divisor       = '0;
        div_in_valid  = 1'b0;
        div_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(div_in_ready), 64'd1);
        chk("rst_out_valid", 64'(div_out_valid), 64'd0);
        chk("rst_result", div_result, 64'd0);
        reset = 1'b0;

        run_div(2'b01, 32'd7,          32'd2,          64'h00000001_00000003, 0, 1'b0);
        run_div(2'b01, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 1, 1'b0);
        run_div(2'b01, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 0, 1'b0);
        run_div(2'b10, 32'hFFFF_FFFF,  32'h10,         64'h0000000F_0FFFFFFF, 0, 1'b0);
        run_div(2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 0, 1'b0);
        run_div(2'b10, 32'h1234,       32'd0,          64'h00001234_FFFFFFFF, 0, 1'b0);
        run_div(2'b01, 32'hFFFF_FFF0,  32'd0,          64'hFFFFFFF0_00000001, 0, 1'b0);
        run_div(2'b00, 32'hFFFF_FFF9,  32'd2,          64'h00000001_7FFFFFFC, 5, 1'b1);
        run_div(2'b11, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 2, 1'b1);

        // Abort in the middle of BUSY; the earlier result must be discarded.
        div_op       = 2'b01;
        dividend     = 32'd1000;
        divisor      = 32'd3;
        div_in_valid = 1'b1;
        @(posedge clk); #1;
        div_in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_in_ready", 64'(div_in_ready), 64'd1);
        chk("abort_out_valid", 64'(div_out_valid), 64'd0);
        chk("abort_result", div_result, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_output", 64'(div_out_valid), 64'd0);
        run_div(2'b01, 32'd100, 32'd7, 64'h00000002_0000000E, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            run_div(op, a, b, ref_div(op, a, b), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
